// File: rtl/sclk_gen.sv
// Serial-clock generator: programmable half-period, idle polarity and burst length with edge strobes and busy/done.
// Optional free-run/abort support is enabled by defining SCLK_GEN_FREERUN_EN.
module sclk_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cpol,
  input  logic [DIV_W-1:0] divisor,
  input  logic [CNT_W-1:0] cycles,
  output logic             sclk,
  output logic             sclkPosEdge,
  output logic             sclkNegEdge,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TGL_W = CNT_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] hcnt;
  logic [CNT_W-1:0] cycles_q;
  logic             cpol_q;
  logic [TGL_W-1:0] tcnt;

  logic             half_end_c;
  logic             last_tgl_c;
  logic             abort_c;
  logic             end_c;

  assign half_end_c = (hcnt == div_q);

  // Compare before increment: 2*cycles-1 wraps to all-ones for cycles=0, so 2^(CNT_W+1) toggles never overflow
`ifdef SCLK_GEN_FREERUN_EN
  logic abort_q;

  assign last_tgl_c = (cycles_q != '0) && (tcnt == ({cycles_q, 1'b0} - TGL_W'(1)));
  assign abort_c    = abort_q | stop;
`else
  logic unused_stop;

  assign unused_stop = stop;
  assign last_tgl_c  = (tcnt == ({cycles_q, 1'b0} - TGL_W'(1)));
  assign abort_c     = 1'b0;
`endif

  // An abort only ends the burst on a toggle that lands back on the idle level
  assign end_c = last_tgl_c | (abort_c & (sclk != cpol_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div_q       <= '0;
      hcnt        <= '0;
      cycles_q    <= '0;
      cpol_q      <= 1'b0;
      tcnt        <= '0;
      sclk        <= 1'b0;
      sclkPosEdge <= 1'b0;
      sclkNegEdge <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef SCLK_GEN_FREERUN_EN
      abort_q     <= 1'b0;
`endif
    end else begin
      sclkPosEdge <= 1'b0;
      sclkNegEdge <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= cpol;
          if (start) begin
            state    <= RUN;
            div_q    <= divisor;
            cpol_q   <= cpol;
            cycles_q <= cycles;
            hcnt     <= '0;
            tcnt     <= '0;
            busy     <= 1'b1;
`ifdef SCLK_GEN_FREERUN_EN
            abort_q  <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef SCLK_GEN_FREERUN_EN
          if (stop) begin
            abort_q <= 1'b1;
          end
`endif
          if (half_end_c) begin
            sclk        <= ~sclk;
            sclkPosEdge <= ~sclk;
            sclkNegEdge <= sclk;
            hcnt        <= '0;
            tcnt        <= tcnt + TGL_W'(1);
            if (end_c) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sclk_gen.sv
// Self-checking bench for sclk_gen: directed table, hand sequences and random stimulus against a timing-formula model.
module tb_sclk_gen;

  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 6;
`ifdef SCLK_GEN_FREERUN_EN
  localparam bit FREERUN = 1'b1;
`else
  localparam bit FREERUN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             cpol = 1'b0;
  logic [DIV_W-1:0] divisor = '0;
  logic [CNT_W-1:0] cycles = '0;
  logic             sclk;
  logic             sclkPosEdge;
  logic             sclkNegEdge;
  logic             busy;
  logic             done;

  sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .cpol       (cpol),
    .divisor    (divisor),
    .cycles     (cycles),
    .sclk       (sclk),
    .sclkPosEdge(sclkPosEdge),
    .sclkNegEdge(sclkNegEdge),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: burst described by start edge offset, half-period and toggle total
  bit       m_busy  = 1'b0;
  bit       m_c     = 1'b0;
  bit       m_abort = 1'b0;
  int       m_d     = 0;
  int       m_total = 0;
  int       m_k     = 0;
  logic [4:0] exp_v = '0;
  logic [4:0] obs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_step();
    int i;
    bit ns;
    bit endn;
    bit stop_eff;
    if (reset) begin
      exp_v   = '0;
      m_busy  = 1'b0;
      m_abort = 1'b0;
    end else if (!m_busy) begin
      exp_v = {cpol, 4'b0000};
      if (start) begin
        m_busy  = 1'b1;
        m_c     = cpol;
        m_d     = int'(divisor);
        m_total = (cycles == '0) ? (FREERUN ? 0 : 2 * (1 << CNT_W)) : 2 * int'(cycles);
        m_k     = 0;
        m_abort = 1'b0;
        exp_v[1] = 1'b1;
      end
    end else begin
      m_k++;
      stop_eff = FREERUN && (m_abort || stop);
      if (FREERUN && stop) m_abort = 1'b1;
      i = m_k / (m_d + 1);
      if (m_k % (m_d + 1) == 0) begin
        ns    = m_c ^ i[0];
        endn  = (m_total != 0 && i == m_total) || (stop_eff && ns == m_c);
        exp_v = {ns, ns, !ns, !endn, endn};
        if (endn) m_busy = 1'b0;
      end else begin
        exp_v = {m_c ^ i[0], 1'b0, 1'b0, 1'b1, 1'b0};
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    obs = {sclk, sclkPosEdge, sclkNegEdge, busy, done};
    chk("outputs_vs_model", 32'(obs), 32'(exp_v));
  endtask

  task automatic start_burst(input bit c, input int d, input int n);
    cpol    = c;
    divisor = DIV_W'(d);
    cycles  = CNT_W'(n);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Ticks until done; t is the offset from the start edge (-1 on timeout)
  task automatic wait_done(input int bound, input int start_k, input int stop_k,
                           output int t, output int npos, output int nneg, output bit s_done);
    t = -1; npos = 0; nneg = 0; s_done = 1'b0;
    for (int k = 2; k <= bound; k++) begin
      start = (k == start_k);
      stop  = (k == stop_k);
      if (k == start_k) begin
        divisor = '0;
        cpol    = ~cpol;
        cycles  = CNT_W'(5);
      end
      tick();
      start = 1'b0;
      stop  = 1'b0;
      if (sclkPosEdge) npos++;
      if (sclkNegEdge) nneg++;
      if (done) begin
        t      = k;
        s_done = sclk;
        break;
      end
    end
  endtask

  typedef struct {
    bit c;
    int d;
    int n;
    int exp_t;
    int exp_np;
    bit exp_s;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int t, np, nn, cnt;
    bit sd;

    vecs.push_back('{c: 1'b0, d: 3, n: 2, exp_t: 17, exp_np: 2, exp_s: 1'b0});
    vecs.push_back('{c: 1'b1, d: 0, n: 3, exp_t: 7,  exp_np: 3, exp_s: 1'b1});
    vecs.push_back('{c: 1'b0, d: 1, n: 1, exp_t: 5,  exp_np: 1, exp_s: 1'b0});
    vecs.push_back('{c: 1'b1, d: 2, n: 4, exp_t: 25, exp_np: 4, exp_s: 1'b1});
    vecs.push_back('{c: 1'b0, d: 0, n: 1, exp_t: 3,  exp_np: 1, exp_s: 1'b0});
    vecs.push_back('{c: 1'b1, d: 5, n: 2, exp_t: 25, exp_np: 2, exp_s: 1'b1});
`ifndef SCLK_GEN_FREERUN_EN
    vecs.push_back('{c: 1'b0, d: 0, n: 0, exp_t: 129, exp_np: 64, exp_s: 1'b0});
`endif

    @(negedge clk);

    // Reset dominates cpol, then idle level follows cpol one edge later
    reset = 1'b1;
    cpol  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset_outputs", 32'(obs), 32'(0));
    end
    reset = 1'b0;
    tick();
    chk("idle_cpol_sclk", 32'(sclk), 32'(1));
    tick();
    cpol = 1'b0;
    tick();
    tick();

    foreach (vecs[v]) begin
      start_burst(vecs[v].c, vecs[v].d, vecs[v].n);
      wait_done(2000, -1, -1, t, np, nn, sd);
      chk("table_done_time", 32'(t), 32'(vecs[v].exp_t));
      chk("table_pos_count", 32'(np), 32'(vecs[v].exp_np));
      chk("table_neg_count", 32'(nn), 32'(vecs[v].exp_np));
      chk("table_done_sclk", 32'(sd), 32'(vecs[v].exp_s));
      tick();
      tick();
    end

    // Basic burst strobe positions
    start_burst(1'b0, 3, 2);
    chk("basic_busy_t1", 32'(busy), 32'(1));
    for (int k = 2; k <= 17; k++) begin
      tick();
      if (k == 5 || k == 13) chk("basic_pos", 32'(sclkPosEdge), 32'(1));
      if (k == 9 || k == 17) chk("basic_neg", 32'(sclkNegEdge), 32'(1));
      if (k == 17) chk("basic_done_busy", 32'({done, busy}), 32'(2'b10));
    end
    tick();

    // Start during a burst is ignored
    cpol = 1'b0;
    start_burst(1'b0, 3, 2);
    wait_done(100, 7, -1, t, np, nn, sd);
    chk("ignored_start_done", 32'(t), 32'(17));
    chk("ignored_start_tgl", 32'(np + nn), 32'(4));
    cpol = 1'b0;
    tick();
    tick();

`ifdef SCLK_GEN_FREERUN_EN
    // Free-run with early stop while sclk is high
    start_burst(1'b0, 1, 0);
    for (int k = 0; k < 10; k++) tick();
    cnt = 0;
    while (!sclk && cnt < 4) begin
      tick();
      cnt++;
    end
    chk("freerun_sclk_high", 32'(sclk), 32'(1));
    wait_done(5, -1, 2, t, np, nn, sd);
    chk("stop_latency_ok", 32'(t > 0), 32'(1));
    chk("stop_done_sclk", 32'(sd), 32'(0));
    chk("stop_no_pos", 32'(np), 32'(0));
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cnt += int'(sclkPosEdge) + int'(sclkNegEdge);
    end
    chk("stop_no_strobes_after", 32'(cnt), 32'(0));
`else
    // Stop has no effect without the free-run feature
    start_burst(1'b0, 0, 3);
    wait_done(50, -1, 3, t, np, nn, sd);
    chk("stop_ignored_done", 32'(t), 32'(7));
    chk("stop_ignored_pos", 32'(np), 32'(3));
    tick();
`endif

    // Reset mid-burst, then a clean burst
    start_burst(1'b1, 3, 2);
    for (int k = 0; k < 6; k++) tick();
    chk("mid_busy_before_reset", 32'(busy), 32'(1));
    reset = 1'b1;
    tick();
    chk("mid_reset_outputs", 32'(obs), 32'(0));
    reset = 1'b0;
    cpol  = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt += int'(done);
    end
    chk("mid_reset_no_done", 32'(cnt), 32'(0));
    start_burst(1'b0, 3, 2);
    wait_done(100, -1, -1, t, np, nn, sd);
    chk("post_reset_burst_done", 32'(t), 32'(17));

    // Random stimulus against the model
    for (int k = 0; k < 3000; k++) begin
      reset   = ($urandom_range(0, 199) == 0);
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 7) == 0);
      cpol    = 1'($urandom_range(0, 1));
      divisor = DIV_W'($urandom_range(0, 4));
      cycles  = ($urandom_range(0, 15) == 0) ? '0 : CNT_W'($urandom_range(1, 4));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
